// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: burst sequencer for a 3-bit loadable up-counter.
// Each accepted start runs 1..4 passes. A pass loads sv_q into the
// counter, then increments it until the counter reports carry (7).
// done pulses for one cycle after the final pass completes.
module count_seq_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [2:0] start_val_i,
  input  logic [1:0] passes_i,
  input  logic       hold_i,
  input  logic       cnt_carry_i,
  output logic       cnt_ld_o,
  output logic       cnt_inc_o,
  output logic [2:0] cnt_data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] pass_idx_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] sv_q, sv_d;
  logic [1:0] np_q, np_d;
  logic [1:0] pidx_q, pidx_d;

  // State and burst-parameter registers; reset drops any burst in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sv_q    <= 3'd0;
      np_q    <= 2'd0;
      pidx_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      sv_q    <= sv_d;
      np_q    <= np_d;
      pidx_q  <= pidx_d;
    end
  end

  // Next-state and strobe decode. cnt_inc is Mealy on hold/carry so the
  // counter stops on the very cycle it reaches 7 or a hold arrives.
  always_comb begin
    state_d    = state_q;
    sv_d       = sv_q;
    np_d       = np_q;
    pidx_d     = pidx_q;
    cnt_ld_o   = 1'b0;
    cnt_inc_o  = 1'b0;
    cnt_data_o = 3'd0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Parameters are latched only here, so later input changes
        // cannot disturb a running burst.
        if (start_i) begin
          state_d = S_LOAD;
          sv_d    = start_val_i;
          np_d    = passes_i;
          pidx_d  = 2'd0;
        end
      end
      S_LOAD: begin
        busy_o     = 1'b1;
        cnt_ld_o   = 1'b1;
        cnt_data_o = sv_q;
        state_d    = S_COUNT;
      end
      S_COUNT: begin
        busy_o    = 1'b1;
        cnt_inc_o = ~cnt_carry_i & ~hold_i;
        // hold freezes the pass entirely, even on the carry cycle.
        if (!hold_i && cnt_carry_i) begin
          if (pidx_q == np_q) begin
            state_d = S_DONE;
          end else begin
            // np_q <= 3 bounds pidx_q, so this never wraps.
            pidx_d  = pidx_q + 2'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The pass index stays visible after DONE until the next start clears it.
  assign pass_idx_o = pidx_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: a 3-bit counter model closes the loop on
// cnt_carry, and each burst is checked against an expected per-cycle trace
// built from the pass/hold rules.
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, hold, carry;
  logic [2:0] sval;
  logic [1:0] npass;
  logic       ld, inc, busy, done;
  logic [2:0] data;
  logic [1:0] pidx;
  logic [2:0] cnt = 3'd0;

  int n_cmp = 0;
  int n_err = 0;
  int last_np = 0;

  typedef struct {
    bit         h;
    logic [8:0] exp;
    int         cv;
  } step_t;

  count_seq_ctrl dut (
    .clk(clk), .reset(reset), .start_i(start), .start_val_i(sval),
    .passes_i(npass), .hold_i(hold), .cnt_carry_i(carry),
    .cnt_ld_o(ld), .cnt_inc_o(inc), .cnt_data_o(data),
    .busy_o(busy), .done_o(done), .pass_idx_o(pidx)
  );

  always #5 clk = ~clk;

  // Counter datapath the controller drives.
  always @(posedge clk) begin
    if (ld) cnt <= data;
    else if (inc) cnt <= cnt + 3'd1;
  end
  assign carry = (cnt == 3'd7);

  wire [8:0] obs = {busy, done, ld, inc, data, pidx};

  function automatic logic [8:0] pk(bit b, bit d, bit l, bit i, int dat, int p);
    return {b, d, l, i, 3'(dat), 2'(p)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One cycle: drive inputs after the falling edge, sample 1 time unit later.
  task automatic step(input bit r, input bit s, input int v, input int n, input bit h);
    @(negedge clk);
    reset = r; start = s; sval = 3'(v); npass = 2'(n); hold = h;
    #1;
  endtask

  // mode 0: hold low; 1: random holds; 2: 2 holds at the start value and
  // 1 on the carry cycle of pass 0. rst_at >= 0 asserts reset at that trace step.
  task automatic run_burst(input int s, input int n, input int mode, input int rst_at);
    step_t q[$];
    step_t e;
    int    nh = 0;
    int    v, h, done_at;
    for (int p = 0; p <= n; p++) begin
      e.h = (mode == 1) ? 1'($urandom) : 1'b0;
      e.exp = pk(1, 0, 1, 0, s, p); e.cv = -1; q.push_back(e);
      v = s;
      forever begin
        h = 0;
        if (mode == 1) h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        else if (mode == 2 && p == 0) h = (v == s) ? 2 : (v == 7) ? 1 : 0;
        nh += h;
        for (int k = 0; k < h; k++) begin
          e.h = 1'b1; e.exp = pk(1, 0, 0, 0, 0, p); e.cv = v; q.push_back(e);
        end
        e.h = 1'b0; e.cv = v;
        if (v < 7) begin
          e.exp = pk(1, 0, 0, 1, 0, p); q.push_back(e); v++;
        end else begin
          e.exp = pk(1, 0, 0, 0, 0, p); q.push_back(e); break;
        end
      end
    end
    e.h = (mode == 1) ? 1'($urandom) : 1'b0;
    e.exp = pk(1, 1, 0, 0, 0, n); e.cv = -1; q.push_back(e);

    // Acceptance cycle: still IDLE, previous pass index visible.
    step(0, 1, s, n, 1'($urandom));
    check("idle_accept", 32'(obs), 32'(pk(0, 0, 0, 0, 0, last_np)));
    done_at = -1;
    for (int i = 0; i < q.size(); i++) begin
      // start and new parameters fly around while busy; they must be ignored.
      step(i == rst_at, 1'($urandom), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 3)), q[i].h);
      check($sformatf("trace s%0d n%0d c%0d", s, n, i + 1), 32'(obs), 32'(q[i].exp));
      if (q[i].cv >= 0) check($sformatf("cnt c%0d", i + 1), 32'(cnt), 32'(q[i].cv));
      if (done === 1'b1 && done_at < 0) done_at = i + 1;
      if (i == rst_at) begin
        step(0, 0, 0, 0, 1'($urandom));
        check("post_reset", 32'(obs), 32'(pk(0, 0, 0, 0, 0, 0)));
        step(0, 0, 0, 0, 1'b0);
        check("post_reset2", 32'(obs), 32'(pk(0, 0, 0, 0, 0, 0)));
        check("no_done_after_reset", 32'(done_at), 32'(-1));
        last_np = 0;
        return;
      end
    end
    check("done_latency", 32'(done_at), 32'((n + 1) * (9 - s) + 1 + nh));
    step(0, 0, 0, 0, 1'($urandom));
    check("idle_after", 32'(obs), 32'(pk(0, 0, 0, 0, 0, n)));
    last_np = n;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0; sval = 3'd0; npass = 2'd0;
    step(1, 0, 0, 0, 0);
    check("reset1", 32'(obs), 32'(pk(0, 0, 0, 0, 0, 0)));
    step(1, 0, 0, 0, 0);
    check("reset2", 32'(obs), 32'(pk(0, 0, 0, 0, 0, 0)));
    step(0, 0, 0, 0, 1);
    check("idle", 32'(obs), 32'(pk(0, 0, 0, 0, 0, 0)));

    run_burst(5, 0, 0, -1);  // done in cycle 5
    run_burst(7, 3, 0, -1);  // ld only, done in cycle 9
    run_burst(4, 1, 2, -1);  // done in cycle 14
    run_burst(3, 2, 0, 8);   // reset in the second COUNT cycle of pass 1
    run_burst(0, 3, 0, -1);  // longest burst
    for (int b = 0; b < 25; b++)
      run_burst(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
